dmem_lsu: RTL and testbench

Parametrised byte-addressed data memory with a load/store front end for the CPU datapath.
- Supports byte, halfword, word and (when 64-bit) doubleword accesses.
- Loads are sign- or zero-extended; stores use per-byte lane enables.
- Misaligned accesses are rejected.
- Uses a valid/ready request channel and a valid/ready response channel, with one request outstanding at a time.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_align.sv | 51 +++++
 rtl/dmem_lsu.sv | 123 ++++++++++++
 tb/tb_dmem_lsu.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Size codes, FSM state encoding, access width and byte-lane mask functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Lane mask sized for the widest (8-lane) word; narrower users slice it.
    function automatic logic [7:0] lane_mask_of(input logic [1:0] size, input logic [2:0] offset);
        return 8'(((16'd1 << size_bytes(size)) - 16'd1) << offset);
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering for dmem_lsu: store lane mask and shift,
// load byte selection with sign/zero extension, and misalignment detection.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter int OFF_W      = $clog2(LANES)
) (
    input  logic [1:0]            size,
    input  logic                  is_signed,
    input  logic [OFF_W-1:0]      offset,
    input  logic [DATA_WIDTH-1:0] rdata_raw,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [LANES-1:0]      lane_mask,
    output logic [DATA_WIDTH-1:0] wdata_shift,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  misalign
);

    logic [7:0]            mask_full;
    logic                  unused_mask;
    logic [3:0]            off_ext;
    logic [6:0]            nbits;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic [DATA_WIDTH-1:0] top_bit;

    assign mask_full   = lane_mask_of(size, 3'(offset));
    assign lane_mask   = mask_full[LANES-1:0];
    assign unused_mask = ^mask_full;

    assign off_ext  = 4'(offset);
    assign misalign = ((size == SZ_D) && (DATA_WIDTH == 32)) ||
                      ((off_ext & (size_bytes(size) - 4'd1)) != 4'd0);

    assign wdata_shift = wdata << {offset, 3'b000};

    // A full-width keep mask leaves ~keep_mask empty, so full-width loads ignore is_signed.
    always_comb begin
        shifted   = rdata_raw >> {offset, 3'b000};
        nbits     = {size_bytes(size), 3'b000};
        keep_mask = (DATA_WIDTH'(1) << nbits) - DATA_WIDTH'(1);
        top_bit   = keep_mask & ~(keep_mask >> 1);
        if (is_signed && (|(shifted & top_bit)))
            rdata_ext = shifted | ~keep_mask;
        else
            rdata_ext = shifted & keep_mask;
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with a valid/ready load/store front end, one request in flight.
// Build option DMEM_TEST_INIT_EN preloads word i with value i at time 0.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state, state_nxt;
    logic                  accept;
    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [IDX_W-1:0]      lat_idx;
    logic [OFF_W-1:0]      lat_off;
    logic [LANES-1:0]      lane_mask;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] rdata_ext;
    logic                  misalign;

`ifdef DMEM_TEST_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_WIDTH'(i);
    end
`endif

    assign lat_idx = lat_addr[ADDR_WIDTH-1:OFF_W];
    assign lat_off = lat_addr[OFF_W-1:0];
    assign accept  = req_valid && req_ready;

    dmem_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .OFF_W      (OFF_W)
    ) u_align (
        .size        (lat_size),
        .is_signed   (lat_signed),
        .offset      (lat_off),
        .rdata_raw   (mem[lat_idx]),
        .wdata       (lat_wdata),
        .lane_mask   (lane_mask),
        .wdata_shift (wdata_shift),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) state_nxt = req_valid ? ST_ACCESS : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_ACCESS) begin
                rsp_err   <= misalign;
                rsp_rdata <= (lat_we || misalign) ? '0 : rdata_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    // Reset taken during ACCESS must cancel the write, hence the !rst gate.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_ACCESS && lat_we && !misalign) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_mask[l]) mem[lat_idx][8*l +: 8] <= wdata_shift[8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu (32-bit data): directed scenarios plus a randomized
// sequence checked against a byte-level memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [0:16383];

    dmem_lsu #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: memory viewed as bytes, accesses applied from the architectural rules.
    function automatic void model_txn(input logic we, input logic [1:0] sz, input logic sg,
                                      input logic [15:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er);
        int nb;
        int ba;
        logic [63:0] v;
        nb = 1 << sz;
        er = (sz == 2'd3) || ((int'(a) % nb) != 0);
        rd = 32'h0;
        if (er) return;
        v = 64'h0;
        for (int b = 0; b < nb; b++) begin
            ba = int'(a) + b;
            if (we)
                mem_model[ba / 4][8*(ba % 4) +: 8] = wd[8*b +: 8];
            else
                v = v | (64'(mem_model[ba / 4][8*(ba % 4) +: 8]) << (8*b));
        end
        if (!we) begin
            if (sg && nb < 4 && (((v >> (8*nb - 1)) & 64'h1) == 64'h1))
                v = v | ~((64'h1 << (8*nb)) - 64'h1);
            rd = v[31:0];
        end
    endfunction

    // Drive one request from IDLE, wait for its response, consume it.
    task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 16'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        rst = 1'b0;
    endtask

    task automatic preload();
        logic [31:0] rd;
        logic er;
        int lat;
        for (int i = 0; i < 64; i++) do_txn(1'b1, 2'd2, 1'b0, 16'(4*i), 32'(i), rd, er, lat);
    endtask

    task automatic test_basic_load();
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd, er, lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++;
        if (rd !== 32'h0000_0004 || er !== 1'b0) begin
            failures++; $display("FAIL basic_load got=%h err=%b exp=00000004 err=0", rd, er);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        do_txn(1'b1, 2'd2, 1'b0, 16'h0020, 32'h8000_00F0, rd, er, lat);
        model_txn(1'b1, 2'd2, 1'b0, 16'h0020, 32'h8000_00F0, mrd, mer);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL store_rsp got=%h err=%b exp=00000000 err=0", rd, er);
        end
        do_txn(1'b0, 2'd0, 1'b1, 16'h0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF_FFF0) begin failures++; $display("FAIL lb_signed got=%h exp=fffffff0", rd); end
        do_txn(1'b0, 2'd0, 1'b0, 16'h0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_00F0) begin failures++; $display("FAIL lb_unsigned got=%h exp=000000f0", rd); end
        do_txn(1'b0, 2'd1, 1'b1, 16'h0022, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF_8000) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8000", rd); end
        do_txn(1'b0, 2'd2, 1'b1, 16'h0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h8000_00F0) begin failures++; $display("FAIL lw_signed_ignored got=%h exp=800000f0", rd); end
    endtask

    task automatic test_byte_merge();
        logic [31:0] rd, mrd;
        logic er, mer;
        int lat;
        do_txn(1'b1, 2'd0, 1'b0, 16'h0031, 32'h0000_00AB, rd, er, lat);
        model_txn(1'b1, 2'd0, 1'b0, 16'h0031, 32'h0000_00AB, mrd, mer);
        do_txn(1'b0, 2'd2, 1'b0, 16'h0030, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_AB0C) begin failures++; $display("FAIL byte_merge got=%h exp=0000ab0c", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(1'b1, 2'd1, 1'b0, 16'h0041, 32'h0000_FFFF, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL misalign_store got=%h err=%b exp=00000000 err=1", rd, er);
        end
        do_txn(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_0010 || er !== 1'b0) begin
            failures++; $display("FAIL misalign_no_write got=%h err=%b exp=00000010 err=0", rd, er);
        end
        do_txn(1'b0, 2'd3, 1'b0, 16'h0040, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL size3_err got=%h err=%b exp=00000000 err=1", rd, er);
        end
        do_txn(1'b0, 2'd2, 1'b0, 16'h0042, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin failures++; $display("FAIL misalign_word got err=%b exp=1", er); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_addr = 16'h0014;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h4 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d got valid=%b rdata=%h ready=%b exp 1 00000004 0",
                         c, rsp_valid, rsp_rdata, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        @(posedge clk);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_access_gap got=%b exp=0", rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5) begin
            failures++; $display("FAIL b2b_second got valid=%b rdata=%h exp 1 00000005", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 16'h0050; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++; $display("FAIL rst_access_idle cyc=%0d got valid=%b ready=%b exp 0 1", c, rsp_valid, req_ready);
            end
            @(negedge clk);
        end
        do_txn(1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_0014) begin failures++; $display("FAIL rst_suppress_write got=%h exp=00000014", rd); end
        // reset while a response is pending
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0050;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_resp_drop got valid=%b rdata=%h ready=%b exp 0 00000000 1", rsp_valid, rsp_rdata, req_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, wd;
        logic er, mer, we, sg;
        logic [1:0] sz;
        logic [15:0] a;
        int lat;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 255));
            wd = $urandom;
            do_txn(we, sz, sg, a, wd, rd, er, lat);
            model_txn(we, sz, sg, a, wd, mrd, mer);
            checks++;
            if (rd !== mrd || er !== mer || lat !== 2) begin
                failures++;
                $display("FAIL random_%0d we=%b sz=%0d sg=%b a=%h got rdata=%h err=%b lat=%0d exp rdata=%h err=%b lat=2",
                         i, we, sz, sg, a, rd, er, lat, mrd, mer);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem_model[i] = 32'(i);
        test_reset();
`ifndef DMEM_TEST_INIT_EN
        preload();
`endif
        test_basic_load();
        test_store_load();
        test_byte_merge();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
